// File: rtl/mul_sequencer_if.sv
// Host-side handshake bundle for the sequenced multiplier: start/operands in,
// product/flags/status out.
interface mul_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] product;
   logic             ovf;
   logic             busy;
   logic             done;

   modport master (
      output start, a_in, b_in,
      input  product, ovf, busy, done
   );

   modport slave (
      input  start, a_in, b_in,
      output product, ovf, busy, done
   );
endinterface

// File: rtl/mul_sequencer.sv
// Multiply by repeated addition: one shared add/subtract ALU alternates between
// accumulating the product and decrementing the iteration counter.
module mul_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   mul_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TEST,
      S_ADD,
      S_DEC,
      S_DONE
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] x_reg;
   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] p_reg;
   logic             ovf_reg;
   logic             busy_reg;
   logic             done_reg;

   logic             alu_sub;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH:0]   alu_sum;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;

   // Operand mux: (P,X) for accumulation, (CNT,1) for the decrement step.
   always_comb begin
      alu_sub = (state_reg == S_DEC);
      alu_a   = p_reg;
      alu_b   = x_reg;
      if (alu_sub) begin
         alu_a = cnt_reg;
         alu_b = WIDTH'(1);
      end
   end

   // Two's-complement subtract: invert B and inject a carry-in.
   assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b ^ {WIDTH{alu_sub}}} + (WIDTH+1)'(alu_sub);
   assign alu_result = alu_sum[WIDTH-1:0];
   assign alu_carry  = alu_sum[WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         x_reg     <= '0;
         cnt_reg   <= '0;
         p_reg     <= '0;
         ovf_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (bus.start) begin
                  x_reg     <= bus.a_in;
                  cnt_reg   <= bus.b_in;
                  p_reg     <= '0;
                  ovf_reg   <= 1'b0;
                  busy_reg  <= 1'b1;
                  state_reg <= S_TEST;
               end
            end
            S_TEST: begin
               if (cnt_reg == '0) begin
                  done_reg  <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  state_reg <= S_ADD;
               end
            end
            S_ADD: begin
               p_reg     <= alu_result;
               ovf_reg   <= ovf_reg | alu_carry;
               state_reg <= S_DEC;
            end
            S_DEC: begin
               cnt_reg   <= alu_result;
               state_reg <= S_TEST;
            end
            S_DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.product = p_reg;
   assign bus.ovf     = ovf_reg;
   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;

endmodule
